bram_stream_reader: RTL and testbench

- Reads a completed capture buffer out of the dual-clock BRAM read port and streams it as a 64-bit AXI-Stream master toward the DMA engine, on the AXI clock.
- Armed by the capture side's dma_enable. Reads addresses 0..DEPTH-1 in order, tags the final beat with tlast, then returns a one-cycle dma_termination pulse so the capture side can leave its wait state.
- Handles the BRAM's 1-cycle read latency and AXI backpressure with a 2-entry output buffer.

---
 rtl/bram_stream_reader.sv | 157 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a captured BRAM buffer (addresses 0..DEPTH-1) and
// streams it as 64-bit AXI-Stream beats, then pulses dma_termination_o.
`timescale 1ns/1ps
module bram_stream_reader #(
  parameter int unsigned DEPTH = 16384,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          axi_clk,
  input  logic          rst_i,
  input  logic          dma_enable_i,
  output logic [AW-1:0] bram_raddr_o,
  input  logic [63:0]   bram_rdata_i,
  output logic [63:0]   m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          dma_termination_o,
  output logic          busy_o
);

  localparam int unsigned DW = 64;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_TERMINATE
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              enable_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic [1:0][DW-1:0] buf_data_q;
  logic [1:0]        buf_last_q;
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q, count_d;
  logic [2:0]        occupancy_w;
  logic              start_w;
  logic              push_w;
  logic              pop_w;
  logic              issue_w;

  // Output decode straight from registered state and buffer head
  assign m_axis_tvalid     = (count_q != 2'd0);
  assign m_axis_tdata      = buf_data_q[rd_ptr_q];
  assign m_axis_tlast      = m_axis_tvalid & buf_last_q[rd_ptr_q];
  assign bram_raddr_o      = cnt_q;
  assign dma_termination_o = (state_q == ST_TERMINATE);
  assign busy_o            = (state_q != ST_IDLE);

  // Start edge, buffer handshakes and read-issue decision
  always_comb begin
    start_w     = dma_enable_i & ~enable_q;
    pop_w       = m_axis_tvalid & m_axis_tready;
    push_w      = inflight_q;
    occupancy_w = 3'(count_q) + 3'(inflight_q);
    // A beat leaving this cycle frees a slot, which keeps one beat per cycle
    issue_w     = (state_q == ST_STREAM) &&
                  ((occupancy_w < 3'd2) || pop_w);
  end

  // Next-state and read counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_w) begin
          state_d = ST_STREAM;
          cnt_d   = '0;
        end
      end
      ST_STREAM: begin
        if (issue_w) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pop_w && m_axis_tlast) begin
          state_d = ST_TERMINATE;
        end
      end
      ST_TERMINATE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Buffer occupancy update
  always_comb begin
    count_d = count_q;
    unique case ({push_w, pop_w})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state, read counter and enable history
  always_ff @(posedge axi_clk or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      enable_q <= dma_enable_i;
    end
  end

  // Track the read whose data returns next cycle
  always_ff @(posedge axi_clk or posedge rst_i) begin
    if (rst_i) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue_w;
      inflight_last_q <= issue_w && (cnt_q == LAST_ADDR);
    end
  end

  // Two-entry output buffer absorbing read latency and backpressure
  always_ff @(posedge axi_clk or posedge rst_i) begin
    if (rst_i) begin
      buf_data_q <= '0;
      buf_last_q <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      if (push_w) begin
        buf_data_q[wr_ptr_q] <= bram_rdata_i;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_w) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench: a small (DEPTH=8) and a full-size (DEPTH=16384) reader.
`timescale 1ns/1ps
module tb_bram_stream_reader;

  localparam int unsigned DS  = 8;
  localparam int unsigned DB  = 16384;
  localparam int unsigned AWS = 3;
  localparam int unsigned AWB = 14;
  localparam logic [63:0] PAT = 64'hA5A5_0000_0000_0000;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_s, en_s, tvalid_s, tready_s, tlast_s, term_s, busy_s;
  logic [AWS-1:0] raddr_s;
  logic [63:0]    rdata_s, tdata_s;
  logic           rst_b, en_b, tvalid_b, tready_b, tlast_b, term_b, busy_b;
  logic [AWB-1:0] raddr_b;
  logic [63:0]    rdata_b, tdata_b;

  logic [63:0] mem_s [DS];
  logic [63:0] mem_b [DB];

  beat_t q_s[$];
  beat_t q_b[$];
  int errors = 0;
  int checks = 0;
  int beats_b = 0;
  int rmode = 0;

  bram_stream_reader #(.DEPTH(DS)) u_small (
    .axi_clk(clk), .rst_i(rst_s), .dma_enable_i(en_s),
    .bram_raddr_o(raddr_s), .bram_rdata_i(rdata_s),
    .m_axis_tdata(tdata_s), .m_axis_tvalid(tvalid_s), .m_axis_tready(tready_s),
    .m_axis_tlast(tlast_s), .dma_termination_o(term_s), .busy_o(busy_s)
  );

  bram_stream_reader #(.DEPTH(DB)) u_big (
    .axi_clk(clk), .rst_i(rst_b), .dma_enable_i(en_b),
    .bram_raddr_o(raddr_b), .bram_rdata_i(rdata_b),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
    .m_axis_tlast(tlast_b), .dma_termination_o(term_b), .busy_o(busy_b)
  );

  // BRAM read ports with one cycle of latency
  always @(posedge clk) rdata_s <= mem_s[raddr_s];
  always @(posedge clk) rdata_b <= mem_b[raddr_b];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ready generator: 0 always ready, 1 random, 2 stall whenever tlast shows
  initial begin
    tready_s = 1'b0;
    tready_b = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       tready_s = 1'b1;
        1:       tready_s = 1'($urandom_range(0, 1));
        2:       tready_s = !(tvalid_s && tlast_s);
        default: tready_s = 1'b0;
      endcase
    end
  end

  // Monitor: pops scoreboard on handshakes, checks hold-stability and pulse
  logic  stall_s = 1'b0, stall_b = 1'b0, expt_s = 1'b0, expt_b = 1'b0;
  beat_t lst_s, lst_b, e_s, e_b;
  always @(negedge clk) begin
    if (rst_s) begin
      stall_s = 1'b0;
      expt_s  = 1'b0;
    end else begin
      if (stall_s) begin
        chk("hold_valid_s", 64'(tvalid_s), 64'd1);
        chk("hold_data_s", tdata_s, lst_s.data);
        chk("hold_last_s", 64'(tlast_s), 64'(lst_s.last));
      end
      if (term_s || expt_s) chk("term_s", 64'(term_s), 64'(expt_s));
      expt_s = 1'b0;
      if (tvalid_s && tready_s) begin
        if (q_s.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_s: unexpected beat %h, expected none", tdata_s);
        end else begin
          e_s = q_s.pop_front();
          chk("data_s", tdata_s, e_s.data);
          chk("last_s", 64'(tlast_s), 64'(e_s.last));
        end
        expt_s = tlast_s;
      end
      stall_s    = tvalid_s && !tready_s;
      lst_s.data = tdata_s;
      lst_s.last = tlast_s;
    end
    if (rst_b) begin
      stall_b = 1'b0;
      expt_b  = 1'b0;
    end else begin
      if (stall_b) begin
        chk("hold_valid_b", 64'(tvalid_b), 64'd1);
        chk("hold_data_b", tdata_b, lst_b.data);
      end
      if (term_b || expt_b) chk("term_b", 64'(term_b), 64'(expt_b));
      expt_b = 1'b0;
      if (tvalid_b && tready_b) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_b: unexpected beat %h, expected none", tdata_b);
        end else begin
          e_b = q_b.pop_front();
          chk("data_b", tdata_b, e_b.data);
          chk("last_b", 64'(tlast_b), 64'(e_b.last));
        end
        beats_b++;
        expt_b = tlast_b;
      end
      stall_b    = tvalid_b && !tready_b;
      lst_b.data = tdata_b;
      lst_b.last = tlast_b;
    end
  end

  task automatic push_small();
    beat_t b;
    for (int i = 0; i < int'(DS); i++) begin
      b.data = PAT | 64'(i);
      b.last = (i == int'(DS) - 1);
      q_s.push_back(b);
    end
  endtask

  task automatic push_big();
    beat_t b;
    for (int i = 0; i < int'(DB); i++) begin
      b.data = PAT | 64'(i);
      b.last = (i == int'(DB) - 1);
      q_b.push_back(b);
    end
  endtask

  task automatic start_s();
    @(posedge clk); #1 en_s = 1'b0;
    @(posedge clk); #1 en_s = 1'b1;
  endtask

  task automatic wait_done_s(input string tag, input int budget);
    int n = 0;
    while (!term_s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_term_seen"}, 64'(term_s), 64'd1);
    @(negedge clk);
    chk({tag, "_idle_after"}, 64'(busy_s), 64'd0);
    chk({tag, "_queue_empty"}, 64'(q_s.size()), 64'd0);
  endtask

  // Full-size transfer with tready=1; timing measured from the start edge E0
  task automatic run_big(input string tag);
    int fv = -1;
    int lk = -1;
    int tk = -1;
    int np = 0;
    push_big();
    @(posedge clk); #1 en_b = 1'b0;
    @(posedge clk); #1 en_b = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= int'(DB) + 5; k++) begin
      @(negedge clk);
      if (tvalid_b && fv < 0) fv = k;
      if (tvalid_b && tlast_b && lk < 0) lk = k;
      if (term_b) begin
        np++;
        if (tk < 0) tk = k;
      end
    end
    chk({tag, "_first_valid"}, 64'(fv), 64'd2);
    chk({tag, "_last_beat"}, 64'(lk), 64'(DB + 1));
    chk({tag, "_term_cycle"}, 64'(tk), 64'(DB + 2));
    chk({tag, "_term_pulses"}, 64'(np), 64'd1);
    chk({tag, "_busy_end"}, 64'(busy_b), 64'd0);
    chk({tag, "_queue_empty"}, 64'(q_b.size()), 64'd0);
  endtask

  initial begin
    int n;
    rst_s = 1'b1;
    rst_b = 1'b1;
    en_s  = 1'b0;
    en_b  = 1'b0;
    for (int i = 0; i < int'(DS); i++) mem_s[i] = PAT | 64'(i);
    for (int i = 0; i < int'(DB); i++) mem_b[i] = PAT | 64'(i);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid_s", 64'(tvalid_s), 64'd0);
    chk("rst_tlast_s", 64'(tlast_s), 64'd0);
    chk("rst_busy_s", 64'(busy_s), 64'd0);
    chk("rst_term_s", 64'(term_s), 64'd0);
    chk("rst_raddr_s", 64'(raddr_s), 64'd0);
    chk("rst_tdata_s", tdata_s, 64'd0);
    chk("rst_tvalid_b", 64'(tvalid_b), 64'd0);
    chk("rst_raddr_b", 64'(raddr_b), 64'd0);
    @(posedge clk); #1;
    rst_s = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);

    // Full 16384-word transfer
    run_big("full");

    // Random backpressure
    rmode = 1;
    push_small();
    start_s();
    wait_done_s("rand", 400);

    // Stall on the tlast beat for 20 cycles
    rmode = 2;
    push_small();
    start_s();
    n = 0;
    while (!(tvalid_s && tlast_s) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_tlast_seen", 64'(tvalid_s && tlast_s), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_tlast", 64'(tlast_s), 64'd1);
      chk("stall_tdata", tdata_s, PAT | 64'd7);
      chk("stall_no_term", 64'(term_s), 64'd0);
    end
    rmode = 0;
    wait_done_s("stall", 10);

    // Enable held high: no retrigger
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("held_busy", 64'(busy_s), 64'd0);
    end
    push_small();
    start_s();
    wait_done_s("retrig", 100);

    // Enable pulsed low then high during streaming
    rmode = 1;
    push_small();
    start_s();
    repeat (2) @(posedge clk);
    #1 en_s = 1'b0;
    @(posedge clk);
    #1 en_s = 1'b1;
    wait_done_s("pulse", 400);
    repeat (20) @(negedge clk);
    chk("pulse_no_restart", 64'(busy_s), 64'd0);
    chk("pulse_queue_empty", 64'(q_s.size()), 64'd0);

    // Reset in the middle of a full-size transfer
    push_big();
    @(posedge clk); #1 en_b = 1'b0;
    @(posedge clk); #1 en_b = 1'b1;
    n = 0;
    while (beats_b < 100 + int'(DB) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("mid_beats_reached", 64'(beats_b >= 100 + int'(DB)), 64'd1);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    en_b  = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(tvalid_b), 64'd0);
    chk("mid_rst_tlast", 64'(tlast_b), 64'd0);
    chk("mid_rst_busy", 64'(busy_b), 64'd0);
    chk("mid_rst_term", 64'(term_b), 64'd0);
    q_b.delete();
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 64'(busy_b), 64'd0);
    chk("post_rst_tvalid", 64'(tvalid_b), 64'd0);
    run_big("restart");

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
